// File: rtl/rv32i_plic_pkg.sv
// Shared constants for the rv32i_plic_lite interrupt controller.
// Register offsets, claim ID width and default source count.
package rv32i_plic_pkg;

  localparam int ID_W            = 5;
  localparam int NUM_SOURCES_DEF = 8;

  localparam logic [ID_W-1:0] NO_IRQ = '0;

  localparam logic [3:0] OFF_PENDING  = 4'h0;
  localparam logic [3:0] OFF_ENABLE   = 4'h4;
  localparam logic [3:0] OFF_EDGE_SEL = 4'h8;
  localparam logic [3:0] OFF_CLAIM    = 4'hC;

  function automatic logic [3:0] reg_sel(
    input logic [3:0] addr
  );
    return addr & 4'hC;
  endfunction

endpackage

// File: rtl/rv32i_plic_lite_if.sv
// Register access bus of rv32i_plic_lite.
// One-cycle request strobe, fixed one-cycle response.
interface rv32i_plic_lite_if;

  logic        req_valid;
  logic        req_wr;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_wr,
    output req_addr,
    output req_wdata,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_wr,
    input  req_addr,
    input  req_wdata,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/rv32i_plic_gateway.sv
// Per-source gateway: optional 2-flop sync, edge detect, pending, in_flight.
// PLIC_SYNC_EN defined adds the synchronizer on src.
module rv32i_plic_gateway (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_flight
);

  logic smp;
  logic prev;
  logic set;

`ifdef PLIC_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], src};
    end
  end

  assign smp = sync[1];
`else
  assign smp = src;
`endif

  // in_flight is the pre-complete value, so a coincident edge is lost
  assign set = ~in_flight & smp & (~edge_mode | ~prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= 1'b0;
      pending   <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      prev <= smp;
      if (claim) begin
        pending <= 1'b0;
      end else if (set) begin
        pending <= 1'b1;
      end
      if (claim) begin
        in_flight <= 1'b1;
      end else if (complete) begin
        in_flight <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rv32i_plic_lite.sv
// Lite PLIC: register file, claim priority, external_interrupt.
// PLIC_SYNC_EN defined adds 2-flop input synchronizers.
module rv32i_plic_lite
  import rv32i_plic_pkg::*;
#(
  parameter int NUM_SOURCES = NUM_SOURCES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] irq_src,
  rv32i_plic_lite_if.slave       bus,
  output logic                   external_interrupt
);

  logic [NUM_SOURCES-1:0] enable;
  logic [NUM_SOURCES-1:0] edge_sel;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] in_flight;
  logic [NUM_SOURCES-1:0] claim_hot;
  logic [NUM_SOURCES-1:0] claim_vec;
  logic [NUM_SOURCES-1:0] complete_vec;
  logic [ID_W-1:0]        claim_id;
  logic [3:0]             sel;
  logic                   rd;
  logic                   wr;
  logic [31:0]            rdata;

  assign sel = reg_sel(bus.req_addr);
  assign rd  = bus.req_valid & ~bus.req_wr;
  assign wr  = bus.req_valid & bus.req_wr;

  // scan downward so the lowest hit is the one left standing
  always_comb begin
    claim_id  = NO_IRQ;
    claim_hot = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (pending[i] & enable[i]) begin
        claim_id     = ID_W'(i + 1);
        claim_hot    = '0;
        claim_hot[i] = 1'b1;
      end
    end
  end

  assign claim_vec = (rd && sel == OFF_CLAIM) ? claim_hot : '0;

  always_comb begin
    complete_vec = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      complete_vec[i] = wr && (sel == OFF_CLAIM)
                        && (bus.req_wdata == 32'(i + 1));
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (sel)
        OFF_PENDING:  rdata = 32'(pending);
        OFF_ENABLE:   rdata = 32'(enable);
        OFF_EDGE_SEL: rdata = 32'(edge_sel);
        OFF_CLAIM:    rdata = 32'(claim_id);
        default:      rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable             <= '0;
      edge_sel           <= '0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_rdata      <= '0;
      external_interrupt <= 1'b0;
    end else begin
      bus.rsp_valid <= bus.req_valid;
      bus.rsp_rdata <= rdata;
      if (wr && sel == OFF_ENABLE) begin
        enable <= bus.req_wdata[NUM_SOURCES-1:0];
      end
      if (wr && sel == OFF_EDGE_SEL) begin
        edge_sel <= bus.req_wdata[NUM_SOURCES-1:0];
      end
      external_interrupt <= |(pending & enable & ~in_flight);
    end
  end

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_gw
    rv32i_plic_gateway u_gw (
      .clk       (clk),
      .rst       (rst),
      .src       (irq_src[g]),
      .edge_mode (edge_sel[g]),
      .claim     (claim_vec[g]),
      .complete  (complete_vec[g]),
      .pending   (pending[g]),
      .in_flight (in_flight[g])
    );
  end

endmodule

// File: tb/tb_rv32i_plic_lite.sv
// Self-checking bench for rv32i_plic_lite: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_rv32i_plic_lite;

  localparam int NS = 8;
`ifdef PLIC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] irq_src;
  logic          external_interrupt;

  rv32i_plic_lite_if bus ();

  rv32i_plic_lite #(.NUM_SOURCES(NS)) dut (
    .clk                (clk),
    .rst                (rst),
    .irq_src            (irq_src),
    .bus                (bus),
    .external_interrupt (external_interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NS-1:0] cur_src;
  logic          o_rv;
  logic          o_ext;
  logic [31:0]   o_rd;
  logic [31:0]   rdv;

  bit [NS-1:0] m_pend, m_en, m_edge, m_infl, m_last;
  bit [NS-1:0] m_sh [2];
  bit          m_rv, m_ext;
  bit [31:0]   m_rd;

  // one clock edge of the specified behaviour
  task automatic model(input bit r, input bit v, input bit w,
                       input logic [3:0] a, input logic [31:0] d,
                       input logic [NS-1:0] s);
    bit [NS-1:0] smp;
    int id;
    bit irq;
    if (r) begin
      m_pend = '0; m_en = '0; m_edge = '0; m_infl = '0; m_last = '0;
      m_sh[0] = '0; m_sh[1] = '0;
      m_rv = 0; m_rd = 0; m_ext = 0;
      return;
    end
`ifdef PLIC_SYNC_EN
    smp = m_sh[1];
    m_sh[1] = m_sh[0];
    m_sh[0] = s;
`else
    smp = s;
`endif
    id = 0;
    irq = 0;
    for (int i = 0; i < NS; i++) begin
      if (id == 0 && m_pend[i] && m_en[i]) id = i + 1;
      if (m_pend[i] && m_en[i] && !m_infl[i]) irq = 1;
    end
    m_rv = v;
    m_rd = 0;
    if (v && !w) begin
      case (a[3:2])
        2'd0: m_rd = 32'(m_pend);
        2'd1: m_rd = 32'(m_en);
        2'd2: m_rd = 32'(m_edge);
        default: m_rd = 32'(id);
      endcase
    end
    for (int i = 0; i < NS; i++) begin
      bit fire;
      fire = m_edge[i] ? (smp[i] && !m_last[i]) : smp[i];
      if (v && !w && a[3:2] == 2'd3 && id == i + 1) begin
        m_pend[i] = 0;
        m_infl[i] = 1;
      end else begin
        if (fire && !m_infl[i]) m_pend[i] = 1;
        if (v && w && a[3:2] == 2'd3 && d == 32'(i + 1)) m_infl[i] = 0;
      end
      m_last[i] = smp[i];
    end
    if (v && w && a[3:2] == 2'd1) m_en = d[NS-1:0];
    if (v && w && a[3:2] == 2'd2) m_edge = d[NS-1:0];
    m_ext = irq;
  endtask

  task automatic cyc(input bit r, input bit v, input bit w,
                     input logic [3:0] a, input logic [31:0] d);
    rst           = r;
    bus.req_valid = v;
    bus.req_wr    = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    irq_src       = cur_src;
    @(posedge clk);
    model(r, v, w, a, d, cur_src);
    #1;
    o_rv  = bus.rsp_valid;
    o_rd  = bus.rsp_rdata;
    o_ext = external_interrupt;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] data);
    cyc(0, 1, 0, a, 32'h0);
    data = o_rd;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    cyc(0, 1, 1, a, d);
  endtask

  task automatic do_reset();
    cur_src = '0;
    cyc(1, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    cur_src = '0;
    cyc(1, 1, 1, 4'h4, 32'hFF);
    cyc(1, 0, 0, 4'h0, 32'h0);
    checks++;
    if (o_rv !== 1'b0 || o_rd !== 32'h0 || o_ext !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got rv=%0b rd=%0h ext=%0b exp 0 0 0",
               o_rv, o_rd, o_ext);
    end
    for (int i = 0; i < 4; i++) begin
      rd_reg(4'(i * 4), rdv);
      checks++;
      if (o_rv !== 1'b1 || rdv !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d got rv=%0b rd=%0h exp 1 0",
                 i, o_rv, rdv);
      end
    end
  endtask

  task automatic test_level_claim();
    do_reset();
    wr_reg(4'h4, 32'h5);
    cur_src = 8'h04;
    idle(LAT);
    checks++;
    if (o_ext !== 1'b0) begin
      errors++;
      $display("FAIL lvl_early got %0b exp 0", o_ext);
    end
    idle(1);
    checks++;
    if (o_ext !== 1'b1) begin
      errors++;
      $display("FAIL lvl_irq got %0b exp 1", o_ext);
    end
    rd_reg(4'hC, rdv);
    checks++;
    if (rdv !== 32'd3) begin
      errors++;
      $display("FAIL lvl_claim got %0d exp 3", rdv);
    end
    idle(1);
    checks++;
    if (o_ext !== 1'b0) begin
      errors++;
      $display("FAIL lvl_drop got %0b exp 0", o_ext);
    end
    wr_reg(4'hC, 32'd3);
    idle(1);
    rd_reg(4'h0, rdv);
    checks++;
    if (rdv !== 32'h4) begin
      errors++;
      $display("FAIL lvl_repend got %0h exp 4", rdv);
    end
  endtask

  task automatic test_priority();
    do_reset();
    wr_reg(4'h4, 32'h5);
    cur_src = 8'h05;
    idle(LAT + 1);
    rd_reg(4'hC, rdv);
    checks++;
    if (rdv !== 32'd1) begin
      errors++;
      $display("FAIL prio_first got %0d exp 1", rdv);
    end
    cur_src = 8'h04;
    idle(LAT);
    wr_reg(4'hC, 32'd1);
    idle(1);
    rd_reg(4'hC, rdv);
    checks++;
    if (rdv !== 32'd3) begin
      errors++;
      $display("FAIL prio_second got %0d exp 3", rdv);
    end
  endtask

  task automatic test_edge_drop();
    do_reset();
    wr_reg(4'h8, 32'h2);
    wr_reg(4'h4, 32'h2);
    cur_src = 8'h02;
    idle(1);
    cur_src = 8'h00;
    idle(LAT + 1);
    rd_reg(4'hC, rdv);
    checks++;
    if (rdv !== 32'd2) begin
      errors++;
      $display("FAIL edge_claim got %0d exp 2", rdv);
    end
    cur_src = 8'h02;
    idle(1);
    cur_src = 8'h00;
    idle(LAT + 1);
    rd_reg(4'h0, rdv);
    checks++;
    if (rdv !== 32'h0) begin
      errors++;
      $display("FAIL edge_drop got %0h exp 0", rdv);
    end
    wr_reg(4'hC, 32'd2);
    idle(LAT + 1);
    rd_reg(4'hC, rdv);
    checks++;
    if (rdv !== 32'd0) begin
      errors++;
      $display("FAIL edge_none got %0d exp 0", rdv);
    end
  endtask

  task automatic test_masking();
    do_reset();
    cur_src = 8'h10;
    idle(LAT + 1);
    rd_reg(4'h0, rdv);
    checks++;
    if (rdv !== 32'h10 || o_ext !== 1'b0) begin
      errors++;
      $display("FAIL mask_pend got %0h/%0b exp 10/0", rdv, o_ext);
    end
    rd_reg(4'hC, rdv);
    checks++;
    if (rdv !== 32'd0) begin
      errors++;
      $display("FAIL mask_claim got %0d exp 0", rdv);
    end
    wr_reg(4'h4, 32'h10);
    checks++;
    if (o_ext !== 1'b0) begin
      errors++;
      $display("FAIL mask_early got %0b exp 0", o_ext);
    end
    idle(1);
    checks++;
    if (o_ext !== 1'b1) begin
      errors++;
      $display("FAIL mask_rise got %0b exp 1", o_ext);
    end
    wr_reg(4'h4, 32'h0);
    rd_reg(4'h0, rdv);
    checks++;
    if (rdv !== 32'h10) begin
      errors++;
      $display("FAIL mask_keep got %0h exp 10", rdv);
    end
  endtask

  task automatic test_bogus_complete();
    do_reset();
    wr_reg(4'h4, 32'h1);
    cur_src = 8'h01;
    idle(LAT + 1);
    rd_reg(4'hC, rdv);
    checks++;
    if (rdv !== 32'd1) begin
      errors++;
      $display("FAIL bogus_claim got %0d exp 1", rdv);
    end
    wr_reg(4'hC, 32'd0);
    wr_reg(4'hC, 32'd31);
    wr_reg(4'hC, 32'd2);
    idle(LAT + 1);
    rd_reg(4'h0, rdv);
    checks++;
    if (rdv !== 32'h0) begin
      errors++;
      $display("FAIL bogus_infl got %0h exp 0", rdv);
    end
    wr_reg(4'hC, 32'd1);
    idle(1);
    rd_reg(4'h0, rdv);
    checks++;
    if (rdv !== 32'h1) begin
      errors++;
      $display("FAIL bogus_real got %0h exp 1", rdv);
    end
  endtask

  task automatic test_reset_mid_claim();
    do_reset();
    wr_reg(4'h4, 32'h1);
    wr_reg(4'h8, 32'h80);
    cur_src = 8'h01;
    idle(LAT + 1);
    rd_reg(4'hC, rdv);
    cyc(1, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(4'(i * 4), rdv);
      checks++;
      if (rdv !== 32'h0) begin
        errors++;
        $display("FAIL rstmid_reg%0d got %0h exp 0", i, rdv);
      end
    end
    wr_reg(4'h4, 32'h1);
    idle(LAT + 1);
    checks++;
    if (o_ext !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_irq got %0b exp 1", o_ext);
    end
    rd_reg(4'hC, rdv);
    checks++;
    if (rdv !== 32'd1) begin
      errors++;
      $display("FAIL rstmid_claim got %0d exp 1", rdv);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_reg(4'h4, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      rd_reg(4'(i * 4), rdv);
      checks++;
      if (o_rv !== 1'b1 || rdv !== m_rd) begin
        errors++;
        $display("FAIL b2b_%0d got rv=%0b rd=%0h exp 1 %0h",
                 i, o_rv, rdv, m_rd);
      end
    end
    idle(1);
    checks++;
    if (o_rv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got %0b exp 0", o_rv);
    end
  endtask

  task automatic test_random();
    bit          r, v, w;
    logic [3:0]  a;
    logic [31:0] d;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur_src = cur_src ^ NS'($urandom & $urandom);
      end
      r = ($urandom_range(0, 299) == 0);
      v = !r && ($urandom_range(0, 2) != 0);
      w = $urandom_range(0, 1) == 1;
      a = 4'($urandom_range(0, 15));
      d = (a[3:2] == 2'd3) ? 32'($urandom_range(0, 10)) : $urandom;
      if ($urandom_range(0, 31) == 0) d = $urandom;
      cyc(r, v, w, a, d);
      checks++;
      if (o_rv !== m_rv || o_rd !== m_rd || o_ext !== m_ext) begin
        errors++;
        $display("FAIL rand_%0d got rv=%0b rd=%0h ext=%0b exp %0b %0h %0b",
                 n, o_rv, o_rd, o_ext, m_rv, m_rd, m_ext);
      end
    end
  endtask

  initial begin
    cur_src = '0;
    test_reset();
    test_level_claim();
    test_priority();
    test_edge_drop();
    test_masking();
    test_bogus_complete();
    test_reset_mid_claim();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_plic_lite.md
RV32I_PLIC_LITE -- requirements
Module: rv32i_plic_lite

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 8, range 1..31: number of external interrupt sources.
REQ-002 SHALL have parameter ID 0, reserved: ID 0 means "no interrupt"; source i maps to ID i+1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port irq_src  input  NUM_SOURCES  raw interrupt lines from peripherals.
REQ-006 SHALL have port req_valid  input  1  register access strobe, one cycle per access.
REQ-007 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  4  byte offset; bits [3:2] select the register; bits [1:0] are ignored.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port rsp_valid  output  1  access completed.
REQ-011 SHALL have port rsp_rdata  output  32  read data; 0 for writes.
REQ-012 SHALL have port external_interrupt  output  1  drives the core's external_interrupt input.

Function
REQ-013 SHALL implement register 0x0 PENDING (RO, bit i = source i pending).
REQ-014 SHALL implement register 0x4 ENABLE (RW).
REQ-015 SHALL implement register 0x8 EDGE_SEL (RW; 1 = edge mode, 0 = level mode).
REQ-016 SHALL implement register 0xC CLAIM (read) / COMPLETE (write).
REQ-017 SHALL ignore bits of any register at or above NUM_SOURCES on write and SHALL read them as 0.
REQ-018 SHALL ignore writes to PENDING.
REQ-019 SHALL assert rsp_valid exactly one cycle after each req_valid, with no backpressure; back-to-back accesses SHALL be accepted every cycle.
REQ-020 Level mode: pending[i] SHALL be set while the sampled source is high and in_flight[i]=0.
REQ-021 Edge mode: pending[i] SHALL be set on a sampled 0->1 transition while in_flight[i]=0; edges occurring while in_flight SHALL be dropped; repeated edges while pending SHALL merge.
REQ-022 A CLAIM read SHALL return the ID of the lowest-index source with pending&enable, or 0 if there is none.
REQ-023 A CLAIM read SHALL, in the same cycle, clear that source's pending bit and set its in_flight bit.
REQ-024 A COMPLETE write with an ID of an in_flight source SHALL clear that in_flight bit; a write with ID 0, an out-of-range ID or a non-in_flight ID SHALL be ignored.
REQ-025 external_interrupt SHALL be a register of |(pending & enable & ~in_flight), i.e. one cycle after pending is set.
REQ-026 Simultaneous claim and pending-set on the same source: the claim SHALL win; the set SHALL be discarded.
REQ-027 Simultaneous complete and rising edge on the same source: the complete SHALL take effect first, and the edge SHALL NOT be captured.
REQ-028 Clearing an ENABLE bit SHALL leave the pending bit intact.

Reset
REQ-029 rst SHALL clear pending, ENABLE, EDGE_SEL, in_flight, the synchronizer flops, the edge-history flops, rsp_valid, rsp_rdata and external_interrupt to 0.
REQ-030 Reset asserted mid-operation SHALL discard all claims.
REQ-031 An edge-mode source held high through reset release SHALL register as one rising edge.

Configuration
REQ-032 Macro PLIC_SYNC_EN defined: each irq_src bit SHALL pass through a 2-flop synchronizer; irq_src-to-pending latency SHALL be 3 cycles and irq_src-to-external_interrupt latency 4 cycles.
REQ-033 Macro PLIC_SYNC_EN undefined: irq_src SHALL be sampled directly and treated as synchronous to clk; latencies SHALL be 1 and 2 cycles.

Structure
REQ-034 Package rv32i_plic_pkg SHALL hold the register offset constants, ID width (5), the NO_IRQ ID constant and the NUM_SOURCES default.
REQ-035 Per-source logic (synchronizer, edge detect, pending, in_flight) SHALL live in sub-module rv32i_plic_gateway, instantiated NUM_SOURCES times.
REQ-036 Priority selection and the register file SHALL live in the top module.

Verification
REQ-037 Level claim: ENABLE=0x05, irq_src[2]=1 -> external_interrupt=1 after the configured latency; CLAIM returns 3; external_interrupt=0 the next cycle; COMPLETE 3 with source still high -> pending re-sets.
REQ-038 Priority: irq_src[0] and irq_src[2] both high, both enabled -> CLAIM returns 1, then returns 3 after complete/deassert of source 0.
REQ-039 Edge drop: EDGE_SEL[1]=1; pulse src1; claim returns 2; second pulse while in_flight -> PENDING=0, and after COMPLETE 2, CLAIM returns 0.
REQ-040 Masking: irq_src[4]=1, ENABLE=0 -> PENDING=0x10, external_interrupt=0, CLAIM returns 0; set ENABLE[4]=1 -> external_interrupt rises one cycle later.
REQ-041 Bogus complete: write COMPLETE 0 and COMPLETE 31 with one source in_flight -> in_flight is unchanged.
REQ-042 Reset mid-claim: claim source 0, assert rst for 1 cycle -> all registers read 0; a source 0 held high re-pends after the configured latency once ENABLE is reprogrammed.
